// File: rtl/sfu_ctrl_if.sv
// Handshake bundle between the SFU sequencing controller and its FIFO/psum-memory environment.
// The controller takes the master side; the surrounding datapath (or a bench) takes the slave side.
interface sfu_ctrl_if #(
   parameter int ADDR_BW = 11,
   parameter int CNT_BW  = 5
);
   logic               start;
   logic               mode;
   logic [ADDR_BW-1:0] base_addr;
   logic [CNT_BW-1:0]  ofifo_cnt;
   logic               ofifo_rd;
   logic               acc_o;
   logic               mem_wr;
   logic [ADDR_BW-1:0] mem_addr;
   logic               busy;
   logic               done;

   modport master (
      input  start, mode, base_addr, ofifo_cnt,
      output ofifo_rd, acc_o, mem_wr, mem_addr, busy, done
   );

   modport slave (
      output start, mode, base_addr, ofifo_cnt,
      input  ofifo_rd, acc_o, mem_wr, mem_addr, busy, done
   );
endinterface

// File: rtl/sfu_ctrl.sv
// SFU job sequencer: either accumulates KIJ psum vectors per output before writing them (W.S),
// or passes each FIFO entry straight through ReLU to memory (O.S).
module sfu_ctrl #(
   parameter int KIJ     = 9,
   parameter int NUM_OUT = 16,
   parameter int ADDR_BW = 11,
   parameter int CNT_BW  = 5
) (
   input  logic       clk,
   input  logic       reset,
   sfu_ctrl_if.master bus
);
   localparam int OUT_BW = $clog2(NUM_OUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACC,
      S_DRAIN,
      S_WRITE,
      S_PASS,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_BW-1:0]  kij_cnt_q, kij_cnt_d;
   logic [OUT_BW-1:0]  out_cnt_q, out_cnt_d;
   logic               mode_q, mode_d;
   logic [ADDR_BW-1:0] base_q, base_d;

   logic               burst_go;
   logic               fifo_nonempty;
   logic               last_out;
   logic [ADDR_BW-1:0] wr_addr;

   logic               ofifo_rd_c;
   logic               acc_c;
   logic               mem_wr_c;
   logic [ADDR_BW-1:0] mem_addr_c;
   logic               busy_c;
   logic               done_c;

   // A burst may only open with a full KIJ window queued; once open it never stalls.
   assign burst_go      = (state_q == S_ACC) &&
                          ((kij_cnt_q != '0) || (bus.ofifo_cnt >= CNT_BW'(KIJ)));
   assign fifo_nonempty = (bus.ofifo_cnt != '0);
   assign last_out      = (out_cnt_q == OUT_BW'(NUM_OUT - 1));
   assign wr_addr       = base_q + ADDR_BW'(out_cnt_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         kij_cnt_q <= '0;
         out_cnt_q <= '0;
         mode_q    <= 1'b0;
         base_q    <= '0;
      end else begin
         state_q   <= state_d;
         kij_cnt_q <= kij_cnt_d;
         out_cnt_q <= out_cnt_d;
         mode_q    <= mode_d;
         base_q    <= base_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      kij_cnt_d = kij_cnt_q;
      out_cnt_d = out_cnt_q;
      mode_d    = mode_q;
      base_d    = base_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mode_d    = bus.mode;
               base_d    = bus.base_addr;
               kij_cnt_d = '0;
               out_cnt_d = '0;
               state_d   = bus.mode ? S_ACC : S_PASS;
            end
         end
         S_ACC: begin
            if (burst_go) begin
               if (kij_cnt_q == CNT_BW'(KIJ - 1)) begin
                  kij_cnt_d = '0;
                  state_d   = S_DRAIN;
               end else begin
                  kij_cnt_d = kij_cnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: begin
            out_cnt_d = out_cnt_q + 1'b1;
            state_d   = last_out ? S_DONE : (mode_q ? S_ACC : S_PASS);
         end
         S_PASS: begin
            if (fifo_nonempty) begin
               out_cnt_d = out_cnt_q + 1'b1;
               if (last_out) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ofifo_rd_c = 1'b0;
      acc_c      = 1'b0;
      mem_wr_c   = 1'b0;
      busy_c     = (state_q != S_IDLE);
      done_c     = (state_q == S_DONE);
      case (state_q)
         S_ACC: begin
            acc_c      = burst_go;
            ofifo_rd_c = burst_go;
         end
         S_WRITE: mem_wr_c = 1'b1;
         S_PASS: begin
            ofifo_rd_c = fifo_nonempty;
            mem_wr_c   = fifo_nonempty;
         end
         default: ;
      endcase
      // Address is held at zero outside write cycles so reset leaves the bus quiet.
      mem_addr_c = mem_wr_c ? wr_addr : '0;
   end

   assign bus.ofifo_rd = ofifo_rd_c;
   assign bus.acc_o    = acc_c;
   assign bus.mem_wr   = mem_wr_c;
   assign bus.mem_addr = mem_addr_c;
   assign bus.busy     = busy_c;
   assign bus.done     = done_c;
endmodule

// File: tb/tb_sfu_ctrl.sv
// Bench for sfu_ctrl: a fixed vector table, directed multi-cycle sequences, and a random run,
// all checked cycle by cycle against a job-level reference model.
module tb_sfu_ctrl;
   localparam int KIJ     = 9;
   localparam int NUM_OUT = 4;
   localparam int ADDR_BW = 11;
   localparam int CNT_BW  = 5;
   localparam int ASPACE  = 1 << ADDR_BW;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   sfu_ctrl_if #(.ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)) bus ();

   sfu_ctrl #(
      .KIJ(KIJ), .NUM_OUT(NUM_OUT), .ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: job progress expressed as writes done, burst cycles left, pending drain/write.
   bit m_busy, m_mode, m_done;
   int m_base, m_written, m_left, m_post;

   int pops, writes;
   int wr_addrs[$];

   typedef struct {
      bit st; bit md; int ba; int cnt;
      bit acc; bit rd; bit wr; int addr; bit busy; bit done;
   } vec_t;
   vec_t tbl[10];

   function automatic logic [15:0] pack(bit acc, bit rd, bit wr, int addr, bit busy, bit done);
      logic [10:0] a;
      a = addr[10:0];
      return {acc, rd, wr, a, busy, done};
   endfunction

   function automatic logic [15:0] dut_out();
      return {bus.acc_o, bus.ofifo_rd, bus.mem_wr, bus.mem_addr, bus.busy, bus.done};
   endfunction

   function automatic logic [15:0] model_out(int cnt);
      if (!m_busy) return pack(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      if (m_done)  return pack(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      if (m_mode) begin
         if (m_post == 2) return pack(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
         if (m_post == 1) return pack(1'b0, 1'b0, 1'b1, (m_base + m_written) % ASPACE, 1'b1, 1'b0);
         if (m_left > 0 || cnt >= KIJ) return pack(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
         return pack(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      end
      if (cnt != 0) return pack(1'b0, 1'b1, 1'b1, (m_base + m_written) % ASPACE, 1'b1, 1'b0);
      return pack(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
   endfunction

   task automatic model_reset();
      m_busy = 0; m_mode = 0; m_done = 0;
      m_base = 0; m_written = 0; m_left = 0; m_post = 0;
   endtask

   task automatic model_step(bit st, bit md, int ba, int cnt);
      if (!m_busy) begin
         if (st) begin
            m_busy = 1; m_mode = md; m_base = ba; m_written = 0;
            m_left = 0; m_post = 0; m_done = 0;
         end
      end else if (m_done) begin
         m_busy = 0; m_done = 0;
      end else if (m_mode) begin
         if (m_post == 2) m_post = 1;
         else if (m_post == 1) begin
            m_written++; m_post = 0;
            if (m_written == NUM_OUT) m_done = 1;
         end else if (m_left > 0 || cnt >= KIJ) begin
            if (m_left == 0) m_left = KIJ;
            m_left--;
            if (m_left == 0) m_post = 2;
         end
      end else if (cnt != 0) begin
         m_written++;
         if (m_written == NUM_OUT) m_done = 1;
      end
   endtask

   task automatic check(string name, logic [15:0] got, logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got {acc,rd,wr,addr,busy,done}=%0b,%0b,%0b,%h,%0b,%0b required %0b,%0b,%0b,%h,%0b,%0b",
                    name, got[15], got[14], got[13], got[12:2], got[1], got[0],
                    exp[15], exp[14], exp[13], exp[12:2], exp[1], exp[0]);
   endtask

   task automatic check_int(string name, int got, int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, got, exp);
   endtask

   task automatic drive_cycle(bit st, bit md, int ba, int cnt, output logic [15:0] got);
      @(negedge clk);
      bus.start     = st;
      bus.mode      = md;
      bus.base_addr = ba[10:0];
      bus.ofifo_cnt = cnt[4:0];
      #1;
      got = dut_out();
      check("model", got, model_out(cnt));
      if (bus.ofifo_rd) pops++;
      if (bus.mem_wr) begin
         writes++;
         wr_addrs.push_back(int'(bus.mem_addr));
      end
      model_step(st, md, ba, cnt);
   endtask

   // Runs one complete job; optionally re-pulses start with different settings mid-job.
   task automatic run_job(bit md, int ba, int cnt, string tag, int poke);
      logic [15:0] g;
      bit seen;
      pops = 0; writes = 0; wr_addrs.delete();
      drive_cycle(1'b1, md, ba, cnt, g);
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (i == poke) drive_cycle(1'b1, ~md, ba ^ 'h300, cnt, g);
         else           drive_cycle(1'b0, md, ba, cnt, g);
         if (g[0]) seen = 1;
      end
      check_int({tag, "_done_seen"}, int'(seen), 1);
      check_int({tag, "_pops"}, pops, md ? NUM_OUT * KIJ : NUM_OUT);
      check_int({tag, "_writes"}, writes, NUM_OUT);
      for (int k = 0; k < wr_addrs.size(); k++)
         check_int({tag, "_addr"}, wr_addrs[k], (ba + k) % ASPACE);
   endtask

   initial begin
      logic [15:0] g;
      bit seen;

      bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.ofifo_cnt = '0;
      model_reset();

      // O.S pass-through with toggling FIFO count, a base that wraps, and an ignored restart.
      tbl[0] = '{1'b1, 1'b0, 'h7FE, 0, 1'b0, 1'b0, 1'b0, 'h000, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 'h7FE, 1, 1'b0, 1'b1, 1'b1, 'h7FE, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 'h7FE, 0, 1'b0, 1'b0, 1'b0, 'h000, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 'h7FE, 1, 1'b0, 1'b1, 1'b1, 'h7FF, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 'h7FE, 0, 1'b0, 1'b0, 1'b0, 'h000, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 'h100, 1, 1'b0, 1'b1, 1'b1, 'h000, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 'h7FE, 0, 1'b0, 1'b0, 1'b0, 'h000, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 'h7FE, 1, 1'b0, 1'b1, 1'b1, 'h001, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 'h7FE, 1, 1'b0, 1'b0, 1'b0, 'h000, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 'h7FE, 1, 1'b0, 1'b0, 1'b0, 'h000, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      #1 check("reset", dut_out(), 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive_cycle(tbl[i].st, tbl[i].md, tbl[i].ba, tbl[i].cnt, g);
         check("table", g, pack(tbl[i].acc, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].busy, tbl[i].done));
      end

      run_job(1'b1, 'h010, 20, "ws", -1);
      run_job(1'b0, 'h7FF, 20, "os_wrap", -1);
      run_job(1'b1, 'h040, 20, "ws_restart", 15);
      run_job(1'b0, 'h0A0, 20, "os_restart", 1);

      // Burst gating: count below KIJ holds the burst off until it reaches KIJ.
      drive_cycle(1'b1, 1'b1, 'h020, 8, g);
      for (int k = 0; k < 5; k++) begin
         drive_cycle(1'b0, 1'b1, 'h020, 8, g);
         check_int("ws_gate_hold", int'(g[15:14]), 0);
      end
      drive_cycle(1'b0, 1'b1, 'h020, 9, g);
      check_int("ws_gate_open", int'(g[15:14]), 3);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         drive_cycle(1'b0, 1'b1, 'h020, (i < KIJ - 1) ? 0 : 20, g);
         if (g[0]) seen = 1;
      end
      check_int("ws_gate_done_seen", int'(seen), 1);

      // Asynchronous reset in the 5th burst cycle, then a clean job.
      drive_cycle(1'b1, 1'b1, 'h050, 20, g);
      for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 'h050, 20, g);
      @(negedge clk);
      bus.start = 1'b0; bus.ofifo_cnt = 5'd20;
      #1 check("acc_5th", dut_out(), pack(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0));
      #1 reset = 1'b0;
      #1 check("rst_async", dut_out(), 16'h0000);
      model_reset();
      @(negedge clk);
      #1 check("rst_hold", dut_out(), 16'h0000);
      reset = 1'b1;
      run_job(1'b1, 'h060, 20, "post_rst", -1);

      // Random FIFO occupancy and stray start pulses against the model.
      for (int i = 0; i < 800; i++) begin
         drive_cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, ASPACE - 1)), int'($urandom_range(0, 20)), g);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
